bias_add_0: RTL and testbench

Stream consumer for the layer-0 bias FIFO: reads the per-output-channel bias words produced by the bias-ROM streamer into a local register file, then adds the matching bias to each convolution accumulator word and emits saturated results. Sits between the conv_0 MAC array output FIFO and the activation stage. All streams use ap_fifo handshakes (FWFT read side: dout/empty_n/read; write side: din/full_n/write).

---
 rtl/bias_add_0_pkg.sv | 25 ++
 rtl/bias_add_0_regfile.sv | 23 ++
 rtl/bias_add_0.sv | 120 ++++++++++++
 tb/tb_bias_add_0.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_add_0_pkg.sv
// Shared definitions for the layer-0 bias adder: default layer sizes, FSM encoding and the
// saturation classifier used on the widened sum.
package bias_add_0_pkg;

  localparam int unsigned kern_s_k_0  = 16;
  localparam int unsigned coeff_width = 16;

  typedef enum logic {
    StLoad = 1'b0,
    StRun  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SatNone = 2'd0,
    SatPos  = 2'd1,
    SatNeg  = 2'd2
  } sat_e;

  // Top two bits of an ACC_W+1 sum disagree only when the true result overflows ACC_W.
  function automatic sat_e sat_class(input logic sign_ext, input logic sign);
    if (sign_ext == sign) return SatNone;
    return sign_ext ? SatNeg : SatPos;
  endfunction

endpackage

// File: rtl/bias_add_0_regfile.sv
// Per-channel bias storage: one synchronous write port, one asynchronous read port.
module bias_add_0_regfile #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [Width-1:0] i_wdata,
  input  logic [AddrW-1:0] i_raddr,
  output logic [Width-1:0] o_rdata
);

  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bias_add_0.sv
// Layer-0 bias adder: loads KERN biases per frame, then adds the channel bias to each
// accumulator word and emits a saturated result through a single output register.
module bias_add_0
  import bias_add_0_pkg::*;
#(
  parameter int unsigned KERN    = kern_s_k_0,
  parameter int unsigned COEFF_W = coeff_width,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned NPIX    = 1024
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [COEFF_W-1:0] bias_V_dout,
  input  logic               bias_V_empty_n,
  output logic               bias_V_read,
  input  logic [ACC_W-1:0]   acc_V_dout,
  input  logic               acc_V_empty_n,
  output logic               acc_V_read,
  output logic [ACC_W-1:0]   out_V_din,
  input  logic               out_V_full_n,
  output logic               out_V_write
);

  localparam int unsigned ChW  = (KERN > 1) ? $clog2(KERN) : 1;
  localparam int unsigned PixW = (NPIX > 1) ? $clog2(NPIX) : 1;

  state_e            r_state;
  logic [ChW-1:0]    r_ld_cnt;
  logic [ChW-1:0]    r_ch_cnt;
  logic [PixW-1:0]   r_pix_cnt;
  logic              r_out_valid;
  logic [ACC_W-1:0]  r_out_reg;

  logic              w_take;
  logic [COEFF_W-1:0] w_bias;
  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  w_sat;

  // Strobes are suppressed during reset so no word is popped in the reset cycle.
  assign bias_V_read = !ap_rst && (r_state == StLoad) && bias_V_empty_n;
  assign w_take      = !ap_rst && (r_state == StRun) && acc_V_empty_n &&
                       (!r_out_valid || out_V_full_n);
  assign acc_V_read  = w_take;

  assign out_V_write = r_out_valid;
  assign out_V_din   = r_out_reg;

  bias_add_0_regfile #(
    .Depth (KERN),
    .Width (COEFF_W),
    .AddrW (ChW)
  ) u_regfile (
    .i_clk   (ap_clk),
    .i_we    (bias_V_read),
    .i_waddr (r_ld_cnt),
    .i_wdata (bias_V_dout),
    .i_raddr (r_ch_cnt),
    .o_rdata (w_bias)
  );

  assign w_sum = {acc_V_dout[ACC_W-1], acc_V_dout} +
                 {{(ACC_W + 1 - COEFF_W){w_bias[COEFF_W-1]}}, w_bias};

  always_comb begin
    w_sat = w_sum[ACC_W-1:0];
    case (sat_class(w_sum[ACC_W], w_sum[ACC_W-1]))
      SatPos:  w_sat = {1'b0, {(ACC_W - 1){1'b1}}};
      SatNeg:  w_sat = {1'b1, {(ACC_W - 1){1'b0}}};
      default: w_sat = w_sum[ACC_W-1:0];
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state     <= StLoad;
      r_ld_cnt    <= '0;
      r_ch_cnt    <= '0;
      r_pix_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_reg   <= '0;
    end else begin
      if (w_take) begin
        r_out_reg   <= w_sat;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_V_full_n) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        StLoad: begin
          if (bias_V_read) begin
            if (r_ld_cnt == ChW'(KERN - 1)) begin
              r_ld_cnt <= '0;
              r_state  <= StRun;
            end else begin
              r_ld_cnt <= r_ld_cnt + 1'b1;
            end
          end
        end
        StRun: begin
          if (w_take) begin
            if (r_ch_cnt == ChW'(KERN - 1)) begin
              r_ch_cnt <= '0;
              if (r_pix_cnt == PixW'(NPIX - 1)) begin
                r_pix_cnt <= '0;
                r_state   <= StLoad;
              end else begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
              end
            end else begin
              r_ch_cnt <= r_ch_cnt + 1'b1;
            end
          end
        end
        default: r_state <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_add_0.sv
// Directed bench for bias_add_0 with KERN=4, NPIX=2: frame loads, saturation, stalls,
// frame-boundary drain and mid-frame reset.
module tb_bias_add_0;

  localparam int unsigned KERN    = 4;
  localparam int unsigned NPIX    = 2;
  localparam int unsigned COEFF_W = 16;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned NW      = KERN * NPIX;

  typedef logic [COEFF_W-1:0] bvec_t [KERN];
  typedef logic [ACC_W-1:0]   wvec_t [NW];

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic [COEFF_W-1:0] bias_V_dout;
  logic               bias_V_empty_n;
  logic               bias_V_read;
  logic [ACC_W-1:0]   acc_V_dout;
  logic               acc_V_empty_n;
  logic               acc_V_read;
  logic [ACC_W-1:0]   out_V_din;
  logic               out_V_full_n;
  logic               out_V_write;

  int errors = 0;
  int checks = 0;
  logic [ACC_W-1:0] mon_q[$];
  logic [ACC_W-1:0] gold_q[$];

  bias_add_0 #(
    .KERN    (KERN),
    .COEFF_W (COEFF_W),
    .ACC_W   (ACC_W),
    .NPIX    (NPIX)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .bias_V_dout    (bias_V_dout),
    .bias_V_empty_n (bias_V_empty_n),
    .bias_V_read    (bias_V_read),
    .acc_V_dout     (acc_V_dout),
    .acc_V_empty_n  (acc_V_empty_n),
    .acc_V_read     (acc_V_read),
    .out_V_din      (out_V_din),
    .out_V_full_n   (out_V_full_n),
    .out_V_write    (out_V_write)
  );

  always #5 ap_clk = ~ap_clk;

  // Output transfers, sampled mid-cycle while inputs are stable.
  always @(negedge ap_clk) begin
    if (!ap_rst && out_V_write && out_V_full_n) mon_q.push_back(out_V_din);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [ACC_W-1:0] model(input logic [ACC_W-1:0] a,
                                             input logic [COEFF_W-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic load_phase(input bvec_t b, input bit stall);
    int i;
    int cyc;
    i   = 0;
    cyc = 0;
    acc_V_empty_n = 1'b1;
    acc_V_dout    = 32'hDEAD_BEEF;
    while (i < int'(KERN) && cyc < 200) begin
      bias_V_empty_n = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bias_V_dout    = b[i];
      out_V_full_n   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("load_bias_read", 32'(bias_V_read), 32'(bias_V_empty_n));
      check("load_acc_read", 32'(acc_V_read), 32'd0);
      if (bias_V_read) i++;
      tick();
      cyc++;
    end
    if (i < int'(KERN)) check("load_timeout", 32'(i), KERN);
  endtask

  task automatic run_phase(input wvec_t a, input wvec_t e, input bit stall);
    int k;
    int cyc;
    logic took;
    logic stalled;
    logic [ACC_W-1:0] held;
    k   = 0;
    cyc = 0;
    bias_V_empty_n = 1'b1;
    bias_V_dout    = 16'h7777;
    while (k < int'(NW) && cyc < 400) begin
      acc_V_empty_n = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      acc_V_dout    = a[k];
      out_V_full_n  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("run_bias_read", 32'(bias_V_read), 32'd0);
      check("run_acc_read", 32'(acc_V_read),
            32'(acc_V_empty_n && (!out_V_write || out_V_full_n)));
      took    = acc_V_read;
      stalled = out_V_write && !out_V_full_n;
      held    = out_V_din;
      if (took) k++;
      tick();
      cyc++;
      if (took) begin
        check("take_write", 32'(out_V_write), 32'd1);
        check("take_din", out_V_din, e[k-1]);
      end else if (stalled) begin
        check("stall_write", 32'(out_V_write), 32'd1);
        check("stall_hold", out_V_din, held);
      end
    end
    if (k < int'(NW)) check("run_timeout", 32'(k), NW);
  endtask

  task automatic run_frame(input bvec_t b, input wvec_t a, input wvec_t e, input bit stall);
    for (int j = 0; j < int'(NW); j++) gold_q.push_back(e[j]);
    load_phase(b, stall);
    run_phase(a, e, stall);
  endtask

  task automatic flush();
    int cyc;
    cyc = 0;
    acc_V_empty_n  = 1'b0;
    bias_V_empty_n = 1'b0;
    out_V_full_n   = 1'b1;
    while (out_V_write && cyc < 10) begin
      tick();
      cyc++;
    end
    check("flush_idle", 32'(out_V_write), 32'd0);
  endtask

  bvec_t b;
  wvec_t a;
  wvec_t e;

  initial begin
    ap_rst         = 1'b1;
    bias_V_dout    = '0;
    bias_V_empty_n = 1'b1;
    acc_V_dout     = '0;
    acc_V_empty_n  = 1'b1;
    out_V_full_n   = 1'b1;
    tick();
    check("rst_bias_read", 32'(bias_V_read), 32'd0);
    check("rst_acc_read", 32'(acc_V_read), 32'd0);
    tick();
    check("rst_write", 32'(out_V_write), 32'd0);
    check("rst_din", out_V_din, 32'd0);
    ap_rst = 1'b0;

    // Frame 1: no stalls.
    b = '{16'h0001, 16'hFFFE, 16'h0003, 16'hFFFC};
    a = '{32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd10};
    e = '{32'd11, 32'd8, 32'd13, 32'd6, 32'd11, 32'd8, 32'd13, 32'd6};
    run_frame(b, a, e, 1'b0);

    // Frame 2: new bias set, bias bubbles and output backpressure.
    b = '{16'h0000, 16'h0000, 16'h0000, 16'h0007};
    a = '{32'd1, 32'd2, 32'd3, 32'd4, 32'hFFFF_FFF6, 32'd0, 32'd0, 32'hFFFF_FFF9};
    e = '{32'd1, 32'd2, 32'd3, 32'd11, 32'hFFFF_FFF6, 32'd0, 32'd0, 32'd0};
    run_frame(b, a, e, 1'b1);

    // Frame 3: saturation at both rails plus near-rail non-saturating sums.
    b = '{16'h0005, 16'hFFFB, 16'h0000, 16'h0007};
    a = '{32'h7FFF_FFFE, 32'h8000_0002, 32'h1234_5678, 32'h7FFF_FFFF,
          32'hFFFF_FFFF, 32'h8000_0005, 32'h0000_0000, 32'hFFFF_FFF8};
    e = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'h7FFF_FFFF,
          32'h0000_0004, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    run_frame(b, a, e, 1'b1);

    // Frame 4: random data, checked against the behavioural model.
    for (int j = 0; j < int'(KERN); j++) b[j] = 16'($urandom);
    for (int j = 0; j < int'(NW); j++) a[j] = $urandom;
    a[0] = 32'h7FFF_FFF0;
    a[1] = 32'h8000_0010;
    for (int j = 0; j < int'(NW); j++) e[j] = model(a[j], b[j % KERN]);
    run_frame(b, a, e, 1'b1);
    flush();

    // Reset with a stalled word in the output register mid-frame.
    b = '{16'h0009, 16'h0009, 16'h0009, 16'h0009};
    load_phase(b, 1'b0);
    out_V_full_n  = 1'b0;
    acc_V_empty_n = 1'b1;
    acc_V_dout    = 32'd1;
    #1;
    check("abort_take", 32'(acc_V_read), 32'd1);
    tick();
    check("abort_valid", 32'(out_V_write), 32'd1);
    check("abort_backpressure", 32'(acc_V_read), 32'd0);
    ap_rst         = 1'b1;
    bias_V_empty_n = 1'b1;
    #1;
    check("abort_rst_bias_read", 32'(bias_V_read), 32'd0);
    tick();
    ap_rst = 1'b0;
    #1;
    check("abort_write", 32'(out_V_write), 32'd0);
    check("abort_din", out_V_din, 32'd0);
    check("abort_load_state", 32'(bias_V_read), 32'd1);
    check("abort_acc_read", 32'(acc_V_read), 32'd0);

    // Fresh frame after the abort must load biases from index 0.
    b = '{16'd100, 16'hFF9C, 16'd1, 16'd2};
    a = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd50, 32'd50, 32'd50, 32'd50};
    e = '{32'd100, 32'hFFFF_FF9C, 32'd1, 32'd2, 32'd150, 32'hFFFF_FFCE, 32'd51, 32'd52};
    run_frame(b, a, e, 1'b0);
    flush();

    check("out_count", 32'(mon_q.size()), 32'(gold_q.size()));
    for (int j = 0; j < gold_q.size() && j < mon_q.size(); j++) begin
      check("out_seq", mon_q[j], gold_q[j]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
